rr_decode_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource between N requesters.
- The grant is produced by a registered index-plus-enable decoder, so the grant vector is always one-hot or all-zero.
- It sits in front of any shared decoder-addressed resource and sequences which requester owns it. Ownership is held until the requester releases it.

---
 rtl/arb_pkg.sv | 47 ++++
 rtl/idx_decoder.sv | 23 ++
 rtl/rr_decode_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_decode_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared state encoding, default sizes and the rotating first-set
//           search used by rr_decode_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int c_arb_default_n        = 4;
    localparam int c_arb_default_max_hold = 8;
    localparam int c_arb_max_n            = 16;
    localparam int c_arb_idx_max_w        = 4;

    // Returns the first set request strictly after 'last', wrapping modulo n.
    // Returns 'last' unchanged when no request is set.
    function automatic logic [c_arb_idx_max_w-1:0] next_rr_idx(
        input logic [c_arb_max_n-1:0]     req,
        input logic [c_arb_idx_max_w-1:0] last,
        input logic [c_arb_idx_max_w:0]   n
    );
        logic [c_arb_idx_max_w-1:0] mask;
        logic [c_arb_idx_max_w-1:0] cand;
        logic [c_arb_idx_max_w-1:0] sel;
        logic                       found;
        mask  = c_arb_idx_max_w'(n - 1'b1);
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= c_arb_max_n; k++) begin
            cand = (last + c_arb_idx_max_w'(k)) & mask;
            if (!found && (k <= int'(n)) && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/idx_decoder.sv
// ============================================================================
// Module  : idx_decoder
// Brief   : Combinational index-plus-enable to one-hot decoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module idx_decoder #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [N-1:0]     o_onehot
);

    for (genvar g = 0; g < N; g++) begin : g_dec
        assign o_onehot[g] = i_en & (i_idx == IDX_W'(g));
    end

endmodule

`default_nettype wire

// File: rtl/rr_decode_arbiter.sv
// ============================================================================
// Module  : rr_decode_arbiter
// Brief   : Round-robin arbiter with hold-until-release ownership and a
//           registered one-hot grant. Optional forced release after MAX_HOLD
//           cycles when ARB_TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_decode_arbiter
    import arb_pkg::*;
#(
    parameter int N        = c_arb_default_n,
    parameter int MAX_HOLD = c_arb_default_max_hold,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [0:0] c_st_idle = ARB_IDLE;
    localparam logic [0:0] c_st_busy = ARB_BUSY;

    if (N < 2 || N > c_arb_max_n || (N & (N - 1)) != 0 || MAX_HOLD < 2) begin : g_bad_params
        $error("rr_decode_arbiter: N must be a power of two in 2..16 and MAX_HOLD >= 2");
    end

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic [N-1:0]     r_gnt;

    logic [0:0]       w_nxt_state;
    logic [IDX_W-1:0] w_nxt_last;
    logic [IDX_W-1:0] w_nxt_idx;
    logic             w_nxt_valid;
    logic [N-1:0]     w_nxt_gnt;
    logic [IDX_W-1:0] w_search_idx;
    logic             w_owner_req;
    logic             w_hold_expired;

    assign w_owner_req  = req[r_gnt_idx];
    assign w_search_idx = IDX_W'(next_rr_idx(c_arb_max_n'(req),
                                             c_arb_idx_max_w'(r_last),
                                             (c_arb_idx_max_w + 1)'(N)));

    // Release (voluntary or forced) always wins over arbitration; the next
    // owner is chosen in the following IDLE cycle from the updated pointer.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_last  = r_last;
        w_nxt_idx   = r_gnt_idx;
        w_nxt_valid = r_gnt_valid;
        case (r_state)
            c_st_idle: begin
                if (|req) begin
                    w_nxt_idx   = w_search_idx;
                    w_nxt_valid = 1'b1;
                    w_nxt_state = c_st_busy;
                end
            end
            c_st_busy: begin
                if (!w_owner_req || w_hold_expired) begin
                    w_nxt_valid = 1'b0;
                    w_nxt_last  = r_gnt_idx;
                    w_nxt_state = c_st_idle;
                end
            end
            default: begin
                w_nxt_valid = 1'b0;
                w_nxt_state = c_st_idle;
            end
        endcase
    end

    idx_decoder #(
        .N(N)
    ) u_idx_decoder (
        .i_idx    (w_nxt_idx),
        .i_en     (w_nxt_valid),
        .o_onehot (w_nxt_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_last      <= IDX_W'(N - 1);
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt       <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_last      <= w_nxt_last;
            r_gnt_idx   <= w_nxt_idx;
            r_gnt_valid <= w_nxt_valid;
            r_gnt       <= w_nxt_gnt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int c_hold_w = $clog2(MAX_HOLD);

    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_timeout;
    logic                w_force;

    // Counter restarts on every new grant, so it reads k-1 in the k-th cycle.
    assign w_hold_expired = (r_hold_cnt == c_hold_w'(MAX_HOLD - 1));
    assign w_force        = (r_state == c_st_busy) && w_owner_req && w_hold_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if ((r_state == c_st_busy) && (w_nxt_state == c_st_busy)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_hold_expired = 1'b0;
    assign timeout        = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_decode_arbiter.sv
// ============================================================================
// Module  : tb_rr_decode_arbiter
// Brief   : Self-checking bench for rr_decode_arbiter (N=4, MAX_HOLD=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_decode_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_decode_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how many cycles, and who
    // owned it last. Ownership rules computed directly with integer arithmetic.
    int m_owner   = -1;
    int m_last    = N - 1;
    int m_held    = 0;
    bit m_timeout = 1'b0;
    bit m_started = 1'b0;

    always @(posedge clk) begin
        int n_owner, n_last, n_held;
        bit n_to;
        n_owner = m_owner;
        n_last  = m_last;
        n_held  = m_held;
        n_to    = 1'b0;
        if (rst) begin
            n_owner = -1;
            n_last  = N - 1;
            n_held  = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                n_last  = m_owner;
                n_owner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_held == MAX_HOLD) begin
                n_last  = m_owner;
                n_owner = -1;
                n_to    = 1'b1;
            end
`endif
            else begin
                n_held = m_held + 1;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (n_owner < 0 && req[c]) begin
                    n_owner = c;
                    n_held  = 1;
                end
            end
        end
        m_owner   <= n_owner;
        m_last    <= n_last;
        m_held    <= n_held;
        m_timeout <= n_to;
        if (rst) m_started <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic [N-1:0] e_gnt;
            bit ok;
            e_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            ok = (gnt === e_gnt) && (gnt_valid === (m_owner >= 0)) &&
                 (timeout === m_timeout) &&
                 ((m_owner < 0) || (gnt_idx === 2'(m_owner)));
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: gnt=%b idx=%0d valid=%b timeout=%b, required gnt=%b idx=%0d valid=%b timeout=%b",
                         $time, gnt, gnt_idx, gnt_valid, timeout,
                         e_gnt, m_owner, (m_owner >= 0), m_timeout);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int owner;
        int waited;

        rst = 1'b1;
        req = '0;
        step();
        step();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_valid", 32'(gnt_valid), 32'h0);
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_gnt", 32'(gnt), 32'h0);
            chk("idle_timeout", 32'(timeout), 32'h0);
        end

        // Single requester held for 4 cycles
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("single_gnt", 32'(gnt), 32'h4);
            chk("single_idx", 32'(gnt_idx), 32'h2);
        end
        req = 4'b0000;
        step();
        chk("single_release", 32'(gnt), 32'h0);

        // All requesting from reset: order 0,1,2,3,0 with one bubble each
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (!gnt_valid && waited < 8) begin
                step();
                waited++;
            end
            chk("rr_no_extra_bubble", 32'(waited), 32'h0);
            owner = int'(gnt_idx);
            chk("rr_order", 32'(owner), 32'(exp_order[g]));
            step();
            chk("rr_hold", 32'(gnt), 32'(1 << exp_order[g]));
            req[owner] = 1'b0;
            step();
            chk("rr_bubble", 32'(gnt_valid), 32'h0);
            req[owner] = 1'b1;
            step();
        end
        req = 4'b0000;
        step();
        step();

        // Contention: owner 1 keeps the grant while requester 3 waits
        req = 4'b0010;
        step();
        chk("cont_first", 32'(gnt), 32'h2);
        req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cont_hold", 32'(gnt), 32'h2);
        end
        req = 4'b1000;
        step();
        chk("cont_bubble", 32'(gnt), 32'h0);
        step();
        chk("cont_next", 32'(gnt), 32'h8);
        req = 4'b0000;
        step();
        step();

        // Reset while busy; pointer must return to N-1
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        step();
        req = 4'b0001;
        step();
        chk("pre_reset_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        req = 4'b0110;
        step();
        chk("reset_busy_drop", 32'(gnt), 32'h0);
        rst = 1'b0;
        step();
        chk("post_reset_lowest", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        step();

`ifdef ARB_TIMEOUT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < MAX_HOLD; i++) begin
            step();
            chk("to_hold", 32'(gnt), 32'h1);
            chk("to_quiet", 32'(timeout), 32'h0);
        end
        step();
        chk("to_evict_gnt", 32'(gnt), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        step();
        chk("to_regrant_self", 32'(gnt), 32'h1);
        chk("to_pulse_end", 32'(timeout), 32'h0);
        req = 4'b0011;
        for (int i = 1; i < MAX_HOLD; i++) begin
            step();
            chk("to_hold2", 32'(gnt), 32'h1);
        end
        step();
        chk("to_evict2", 32'(timeout), 32'h1);
        step();
        chk("to_regrant_other", 32'(gnt), 32'h2);
`else
        // Without the timeout feature ownership is unbounded
        req = 4'b0001;
        for (int i = 0; i < 2 * MAX_HOLD; i++) begin
            step();
            chk("unbounded_hold", 32'(gnt), 32'h1);
            chk("unbounded_no_timeout", 32'(timeout), 32'h0);
        end
`endif
        req = 4'b0000;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
